glip_channel_mux: RTL and testbench
===================================

Name: glip_channel_mux

Overview:
- Shares one GLIP FIFO stream pair between CHANNELS independent logical channels, in the clk_logic domain next to the GLIP TCP/FPGA top level.
- Outbound: round-robin arbitration at burst granularity. Each burst is framed by one header word carrying the channel id and word count.
- Inbound: decodes header words and demultiplexes the following payload words to the addressed channel.
- Words addressed to nonexistent channels are dropped.

Parameters:
WIDTH, 16, GLIP word width; must be >=16
CHANNELS, 4, number of logical channels; range 2..255
MAX_BURST, 8, max payload words per outbound burst; range 1..2^(WIDTH-8)-1

Ports:
clk_logic  in  1  logic clock (already decided)
rst  in  1  reset: synchronous, active-high (already decided)
fifo_out_data  out  WIDTH  outbound word to GLIP
fifo_out_valid  out  1  outbound valid
fifo_out_ready  in  1  GLIP accepts outbound word
fifo_in_data  in  WIDTH  inbound word from GLIP
fifo_in_valid  in  1  inbound valid
fifo_in_ready  out  1  block accepts inbound word
ch_out_data  in  CHANNELS*WIDTH  per-channel outbound data; channel i at [i*WIDTH +: WIDTH]
ch_out_valid  in  CHANNELS  per-channel outbound valid
ch_out_ready  out  CHANNELS  per-channel outbound ready
ch_out_size  in  CHANNELS*(WIDTH-8)  words the channel guarantees to deliver; 0 = no request
ch_in_data  out  WIDTH  inbound payload, broadcast to all channels
ch_in_valid  out  CHANNELS  one-hot inbound valid
ch_in_ready  in  CHANNELS  per-channel inbound ready
stat_drop_words  out  16  dropped inbound word count (optional feature)

Behaviour:
- Header word: [WIDTH-1:WIDTH-8] = channel id, [WIDTH-9:0] = payload length.
- Reset: outbound FSM enters O_IDLE, inbound FSM enters I_HDR, rr pointer = 0, counters = 0. fifo_out_valid=0, ch_out_ready=0, ch_in_valid=0 and fifo_in_ready=0 while rst is high.
- Outbound FSM:
  - O_IDLE: scan channels with ch_out_size != 0, starting at the rr pointer, wrapping at CHANNELS. Register grant g and len=min(size,MAX_BURST), then go to O_HDR. If no channel has size != 0, stay in O_IDLE. ch_out_valid is not considered.
  - O_HDR: fifo_out_data={g[7:0],len}, fifo_out_valid=1. Go to O_DATA on fifo_out_ready. Data is held stable while stalled.
  - O_DATA: fifo_out_data=ch_out_data[g], fifo_out_valid=ch_out_valid[g], ch_out_ready[g]=fifo_out_ready, all other ch_out_ready=0. Each handshake decrements the count. The handshake at count==1 returns the FSM to O_IDLE and sets rr=(g+1) mod CHANNELS. Bubbles on ch_out_valid[g] stall the burst without losing the grant.
  - Latency: at least one idle cycle between a burst's last word and the next header. Header appears 1 cycle after size goes nonzero when the FSM is idle.
  - A channel's size changing mid-burst has no effect; len is latched in O_IDLE.
- Inbound FSM:
  - I_HDR: fifo_in_ready=1. On a valid word:
    - len==0: discard, stay in I_HDR.
    - id>=CHANNELS: load count=len, go to I_DROP.
    - Otherwise: latch id and count=len, go to I_DATA.
  - I_DATA: ch_in_data=fifo_in_data, ch_in_valid[id]=fifo_in_valid, fifo_in_ready=ch_in_ready[id]. Decrement on handshake; at count==1 handshake go to I_HDR.
  - I_DROP: fifo_in_ready=1. Consume count words, then go to I_HDR.
- The two FSMs are independent; simultaneous in/out traffic is fully concurrent.
- rst mid-burst aborts both FSMs immediately. No partial-burst recovery; the host resynchronises via GLIP logic reset.

Optional Feature:
- Macro: GLIP_CHANNEL_MUX_STATS_EN.
- Defined: stat_drop_words counts every word consumed in I_DROP plus every len==0 header. The counter saturates at 16'hFFFF and is cleared by rst.
- Undefined: stat_drop_words is tied to 16'h0 and no counter logic is built.

Test Plan:
- Ch2 size=5, ch2 valid every cycle, fifo_out_ready=1 -> out stream 16'h0205 then 5 ch2 words; ch_out_ready[2] high for exactly 5 handshakes.
- Ch0,ch1,ch3 sizes=20 each -> bursts in order ch0(len 8), ch1(8), ch3(8), ch0(8)...; headers 16'h0008, 16'h0108, 16'h0308.
- Inbound 16'h0103, A, B, C with ch_in_ready[1] low for 2 cycles mid-burst -> ch_in_valid=4'b0010 for A,B,C in order, no loss; next word is treated as a header.
- Inbound 16'h0702, X, Y, then 16'h0001, Z -> X, Y dropped, Z delivered to ch0; with the macro defined, stat_drop_words=2.
- fifo_out_ready held low during O_HDR for 3 cycles -> header word stable; no ch_out_ready asserted until the header is accepted.
- rst pulsed during O_DATA with 3 words pending -> next cycle fifo_out_valid=0 and all ch_out_ready=0; the next header starts from the rr pointer = 0.

Source files
------------

// File: rtl/glip_channel_mux.sv
// glip_channel_mux: shares one GLIP FIFO stream pair between CHANNELS logical channels using header-framed bursts.
// Define GLIP_CHANNEL_MUX_STATS_EN to build the saturating inbound drop counter on stat_drop_words.

module glip_channel_mux #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                         clk_logic,
    input  logic                         rst,
    output logic [WIDTH-1:0]             fifo_out_data,
    output logic                         fifo_out_valid,
    input  logic                         fifo_out_ready,
    input  logic [WIDTH-1:0]             fifo_in_data,
    input  logic                         fifo_in_valid,
    output logic                         fifo_in_ready,
    input  logic [CHANNELS*WIDTH-1:0]    ch_out_data,
    input  logic [CHANNELS-1:0]          ch_out_valid,
    output logic [CHANNELS-1:0]          ch_out_ready,
    input  logic [CHANNELS*(WIDTH-8)-1:0] ch_out_size,
    output logic [WIDTH-1:0]             ch_in_data,
    output logic [CHANNELS-1:0]          ch_in_valid,
    input  logic [CHANNELS-1:0]          ch_in_ready,
    output logic [15:0]                  stat_drop_words
);
    localparam int LW = WIDTH - 8;

    typedef enum logic [1:0] {O_IDLE = 2'd0, O_HDR = 2'd1, O_DATA = 2'd2} o_state_t;
    typedef enum logic [1:0] {I_HDR = 2'd0, I_DATA = 2'd1, I_DROP = 2'd2} i_state_t;

    o_state_t      o_state_r, o_state_s;
    i_state_t      i_state_r, i_state_s;
    logic [7:0]    grant_r, grant_s, rr_r, rr_s, id_r, id_s;
    logic [LW-1:0] ocnt_r, ocnt_s, icnt_r, icnt_s;
    logic          hi_found_s, lo_found_s;
    logic [7:0]    hi_id_s, lo_id_s, pick_id_s;
    logic [LW-1:0] hi_size_s, lo_size_s, pick_size_s, pick_len_s;
    logic [WIDTH-1:0] sel_data_s;
    logic          sel_valid_s, sel_in_ready_s, drop_inc_s;
    logic [7:0]    hdr_id_s;
    logic [LW-1:0] hdr_len_s;

    assign hdr_id_s   = fifo_in_data[WIDTH-1 -: 8];
    assign hdr_len_s  = fifo_in_data[LW-1:0];
    assign ch_in_data = fifo_in_data;

    // Round-robin pick: first requester at or above rr_r, otherwise the first requester overall
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_id_s    = 8'd0;
        lo_id_s    = 8'd0;
        hi_size_s  = {LW{1'b0}};
        lo_size_s  = {LW{1'b0}};
        for (int j = 0; j < CHANNELS; j++) begin
            if (ch_out_size[j*LW +: LW] != {LW{1'b0}}) begin
                if (!hi_found_s && (8'(j) >= rr_r)) begin
                    hi_found_s = 1'b1;
                    hi_id_s    = 8'(j);
                    hi_size_s  = ch_out_size[j*LW +: LW];
                end else begin
                    hi_found_s = hi_found_s;
                end
                if (!lo_found_s) begin
                    lo_found_s = 1'b1;
                    lo_id_s    = 8'(j);
                    lo_size_s  = ch_out_size[j*LW +: LW];
                end else begin
                    lo_found_s = lo_found_s;
                end
            end else begin
                lo_found_s = lo_found_s;
            end
        end
        pick_id_s   = hi_found_s ? hi_id_s : lo_id_s;
        pick_size_s = hi_found_s ? hi_size_s : lo_size_s;
        pick_len_s  = (pick_size_s > LW'(MAX_BURST)) ? LW'(MAX_BURST) : pick_size_s;
    end

    // Granted channel's outbound word and valid, and addressed channel's inbound ready
    always_comb begin
        sel_data_s     = {WIDTH{1'b0}};
        sel_valid_s    = 1'b0;
        sel_in_ready_s = 1'b0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (grant_r == 8'(j)) begin
                sel_data_s  = ch_out_data[j*WIDTH +: WIDTH];
                sel_valid_s = ch_out_valid[j];
            end else begin
                sel_valid_s = sel_valid_s;
            end
            if (id_r == 8'(j)) begin
                sel_in_ready_s = ch_in_ready[j];
            end else begin
                sel_in_ready_s = sel_in_ready_s;
            end
        end
    end

    // Outbound FSM next state and outputs
    always_comb begin
        o_state_s      = o_state_r;
        grant_s        = grant_r;
        ocnt_s         = ocnt_r;
        rr_s           = rr_r;
        fifo_out_data  = {WIDTH{1'b0}};
        fifo_out_valid = 1'b0;
        ch_out_ready   = {CHANNELS{1'b0}};
        case (o_state_r)
            O_IDLE: begin
                if (hi_found_s || lo_found_s) begin
                    grant_s   = pick_id_s;
                    ocnt_s    = pick_len_s;
                    o_state_s = O_HDR;
                end else begin
                    o_state_s = O_IDLE;
                end
            end
            O_HDR: begin
                fifo_out_data  = {grant_r, ocnt_r};
                fifo_out_valid = 1'b1;
                if (fifo_out_ready) begin
                    o_state_s = O_DATA;
                end else begin
                    o_state_s = O_HDR;
                end
            end
            O_DATA: begin
                fifo_out_data  = sel_data_s;
                fifo_out_valid = sel_valid_s;
                for (int j = 0; j < CHANNELS; j++) begin
                    ch_out_ready[j] = fifo_out_ready & (grant_r == 8'(j));
                end
                if (sel_valid_s && fifo_out_ready) begin
                    if (ocnt_r == LW'(1)) begin
                        o_state_s = O_IDLE;
                        rr_s      = (grant_r == 8'(CHANNELS - 1)) ? 8'd0 : grant_r + 8'd1;
                    end else begin
                        ocnt_s = ocnt_r - LW'(1);
                    end
                end else begin
                    o_state_s = O_DATA;
                end
            end
            default: o_state_s = O_IDLE;
        endcase
        if (rst) begin
            fifo_out_valid = 1'b0;
            ch_out_ready   = {CHANNELS{1'b0}};
        end else begin
            fifo_out_valid = fifo_out_valid;
        end
    end

    // Inbound FSM next state and outputs
    always_comb begin
        i_state_s     = i_state_r;
        id_s          = id_r;
        icnt_s        = icnt_r;
        fifo_in_ready = 1'b0;
        ch_in_valid   = {CHANNELS{1'b0}};
        drop_inc_s    = 1'b0;
        case (i_state_r)
            I_HDR: begin
                fifo_in_ready = 1'b1;
                if (fifo_in_valid) begin
                    if (hdr_len_s == {LW{1'b0}}) begin
                        drop_inc_s = 1'b1;
                    end else if (hdr_id_s >= 8'(CHANNELS)) begin
                        icnt_s    = hdr_len_s;
                        i_state_s = I_DROP;
                    end else begin
                        id_s      = hdr_id_s;
                        icnt_s    = hdr_len_s;
                        i_state_s = I_DATA;
                    end
                end else begin
                    i_state_s = I_HDR;
                end
            end
            I_DATA: begin
                fifo_in_ready = sel_in_ready_s;
                for (int j = 0; j < CHANNELS; j++) begin
                    ch_in_valid[j] = fifo_in_valid & (id_r == 8'(j));
                end
                if (fifo_in_valid && sel_in_ready_s) begin
                    if (icnt_r == LW'(1)) begin
                        i_state_s = I_HDR;
                    end else begin
                        icnt_s = icnt_r - LW'(1);
                    end
                end else begin
                    i_state_s = I_DATA;
                end
            end
            I_DROP: begin
                fifo_in_ready = 1'b1;
                if (fifo_in_valid) begin
                    drop_inc_s = 1'b1;
                    if (icnt_r == LW'(1)) begin
                        i_state_s = I_HDR;
                    end else begin
                        icnt_s = icnt_r - LW'(1);
                    end
                end else begin
                    i_state_s = I_DROP;
                end
            end
            default: i_state_s = I_HDR;
        endcase
        if (rst) begin
            fifo_in_ready = 1'b0;
            ch_in_valid   = {CHANNELS{1'b0}};
        end else begin
            fifo_in_ready = fifo_in_ready;
        end
    end

    // State registers for both FSMs
    always_ff @(posedge clk_logic) begin
        if (rst) begin
            o_state_r <= O_IDLE;
            grant_r   <= 8'd0;
            rr_r      <= 8'd0;
            ocnt_r    <= {LW{1'b0}};
            i_state_r <= I_HDR;
            id_r      <= 8'd0;
            icnt_r    <= {LW{1'b0}};
        end else begin
            o_state_r <= o_state_s;
            grant_r   <= grant_s;
            rr_r      <= rr_s;
            ocnt_r    <= ocnt_s;
            i_state_r <= i_state_s;
            id_r      <= id_s;
            icnt_r    <= icnt_s;
        end
    end

`ifdef GLIP_CHANNEL_MUX_STATS_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of discarded inbound words
    always_ff @(posedge clk_logic) begin
        if (rst) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_inc_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign stat_drop_words = drop_cnt_r;
`else
    logic unused_drop_s;
    assign unused_drop_s   = drop_inc_s;
    assign stat_drop_words = 16'h0000;
`endif

endmodule

// File: tb/tb_glip_channel_mux.sv
// Scoreboard bench for glip_channel_mux: directed outbound/inbound vectors, monitors pop expected words on handshakes.

module tb_glip_channel_mux;
    localparam int W  = 16;
    localparam int CH = 4;
    localparam int LW = W - 8;

    logic              clk_logic = 1'b0;
    logic              rst;
    logic [W-1:0]      fifo_out_data;
    logic              fifo_out_valid;
    logic              fifo_out_ready;
    logic [W-1:0]      fifo_in_data;
    logic              fifo_in_valid;
    logic              fifo_in_ready;
    logic [CH*W-1:0]   ch_out_data;
    logic [CH-1:0]     ch_out_valid;
    logic [CH-1:0]     ch_out_ready;
    logic [CH*LW-1:0]  ch_out_size;
    logic [W-1:0]      ch_in_data;
    logic [CH-1:0]     ch_in_valid;
    logic [CH-1:0]     ch_in_ready;
    logic [15:0]       stat_drop_words;

    int checks = 0;
    int errors = 0;
    logic [W-1:0]  out_q[$];
    logic [23:0]   in_q[$];
    int            widx[CH]    = '{default: 0};
    int            expidx[CH]  = '{default: 0};
    int            ocount[CH]  = '{default: 0};
    logic [CH-1:0] hs_q = '0;

    glip_channel_mux #(.WIDTH(W), .CHANNELS(CH), .MAX_BURST(8)) dut (
        .clk_logic(clk_logic), .rst(rst),
        .fifo_out_data(fifo_out_data), .fifo_out_valid(fifo_out_valid), .fifo_out_ready(fifo_out_ready),
        .fifo_in_data(fifo_in_data), .fifo_in_valid(fifo_in_valid), .fifo_in_ready(fifo_in_ready),
        .ch_out_data(ch_out_data), .ch_out_valid(ch_out_valid), .ch_out_ready(ch_out_ready),
        .ch_out_size(ch_out_size),
        .ch_in_data(ch_in_data), .ch_in_valid(ch_in_valid), .ch_in_ready(ch_in_ready),
        .stat_drop_words(stat_drop_words)
    );

    always #5 clk_logic = ~clk_logic;

    function automatic logic [W-1:0] word_of(input int ch, input int k);
        return {4'hA, 4'(ch), 8'(k)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Channel sources: channel i presents word_of(i, n) where n is its handshake count
    always_comb begin
        ch_out_data = '0;
        for (int i = 0; i < CH; i++) ch_out_data[i*W +: W] = word_of(i, widx[i]);
    end

    initial begin
        forever begin
            @(posedge clk_logic);
            #1;
            for (int i = 0; i < CH; i++) if (hs_q[i]) widx[i]++;
        end
    end

    // Outbound monitor
    always @(negedge clk_logic) begin
        hs_q <= ch_out_valid & ch_out_ready;
        for (int i = 0; i < CH; i++) if (ch_out_valid[i] && ch_out_ready[i]) ocount[i] <= ocount[i] + 1;
        if (fifo_out_valid && fifo_out_ready) begin
            if (out_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got %0h expected no word", fifo_out_data);
            end else begin
                check("out_word", fifo_out_data, out_q.pop_front());
            end
        end
    end

    // Inbound monitor
    always @(negedge clk_logic) begin
        for (int i = 0; i < CH; i++) begin
            if (ch_in_valid[i] && ch_in_ready[i]) begin
                if (in_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL in_unexpected: got ch%0d %0h expected no word", i, ch_in_data);
                end else begin
                    check("in_word", {8'(i), ch_in_data}, in_q.pop_front());
                end
            end
        end
    end

    task automatic push_burst(input int ch, input int len, input int nwords);
        out_q.push_back({8'(ch), 8'(len)});
        for (int k = 0; k < nwords; k++) begin
            out_q.push_back(word_of(ch, expidx[ch]));
            expidx[ch]++;
        end
    endtask

    task automatic wait_out_empty(input string name, input int budget);
        int n = 0;
        while (out_q.size() != 0 && n < budget) begin
            @(posedge clk_logic);
            n++;
        end
        #1;
        check(name, out_q.size(), 0);
    endtask

    task automatic wait_header(input logic [W-1:0] h, input int budget);
        int  n = 0;
        logic seen = 1'b0;
        while (!seen && n < budget) begin
            @(posedge clk_logic);
            #1;
            seen = fifo_out_valid && (fifo_out_data == h);
            n++;
        end
        check("header_seen", seen, 1'b1);
    endtask

    task automatic send_in(input logic [W-1:0] w);
        int   n = 0;
        logic got = 1'b0;
        fifo_in_data  = w;
        fifo_in_valid = 1'b1;
        while (!got && n < 50) begin
            @(negedge clk_logic);
            got = fifo_in_ready;
            @(posedge clk_logic);
            #1;
            n++;
        end
        check("in_accept", got, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; fifo_out_ready = 1'b1; ch_out_valid = '1; ch_out_size = '0;
        fifo_in_data = '0; fifo_in_valid = 1'b0; ch_in_ready = '1;
        repeat (3) @(posedge clk_logic);
        @(negedge clk_logic);
        check("rst_out_valid", fifo_out_valid, 1'b0);
        check("rst_ch_out_ready", ch_out_ready, 4'b0000);
        check("rst_ch_in_valid", ch_in_valid, 4'b0000);
        check("rst_fifo_in_ready", fifo_in_ready, 1'b0);
        @(posedge clk_logic); #1; rst = 1'b0;
        @(negedge clk_logic);
        check("idle_in_ready", fifo_in_ready, 1'b1);
        check("idle_out_valid", fifo_out_valid, 1'b0);
        check("idle_stat", stat_drop_words, 16'h0000);

        // Single ch2 burst of 5
        @(posedge clk_logic); #1;
        ch_out_size[2*LW +: LW] = 8'd5;
        push_burst(2, 5, 5);
        @(posedge clk_logic); #1;
        check("hdr_latency_valid", fifo_out_valid, 1'b1);
        check("hdr_latency_data", fifo_out_data, 16'h0205);
        ch_out_size[2*LW +: LW] = 8'd0;
        wait_out_empty("ch2_drain", 40);
        repeat (3) @(posedge clk_logic);
        #1;
        check("ch2_handshakes", ocount[2], 5);

        // Header held stable while GLIP stalls
        fifo_out_ready = 1'b0;
        ch_out_size[1*LW +: LW] = 8'd2;
        push_burst(1, 2, 2);
        @(posedge clk_logic); #1;
        ch_out_size[1*LW +: LW] = 8'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_logic);
            check("stall_hdr_data", fifo_out_data, 16'h0102);
            check("stall_hdr_valid", fifo_out_valid, 1'b1);
            check("stall_no_ch_ready", ch_out_ready, 4'b0000);
        end
        @(posedge clk_logic); #1;
        fifo_out_ready = 1'b1;
        wait_out_empty("ch1_drain", 40);

        // Reset mid-burst with 3 words pending
        @(posedge clk_logic); #1;
        ch_out_size[2*LW +: LW] = 8'd6;
        push_burst(2, 6, 3);
        @(posedge clk_logic); #1;
        ch_out_size[2*LW +: LW] = 8'd0;
        repeat (4) @(posedge clk_logic);
        #1;
        rst = 1'b1;
        @(negedge clk_logic);
        check("abort_out_valid", fifo_out_valid, 1'b0);
        check("abort_ch_ready", ch_out_ready, 4'b0000);
        @(posedge clk_logic); #1;
        rst = 1'b0;
        @(negedge clk_logic);
        check("post_abort_out_valid", fifo_out_valid, 1'b0);
        check("post_abort_ch_ready", ch_out_ready, 4'b0000);
        check("abort_consumed", out_q.size(), 0);
        @(posedge clk_logic); #1;
        ch_out_size[1*LW +: LW] = 8'd1;
        ch_out_size[3*LW +: LW] = 8'd1;
        push_burst(1, 1, 1);
        push_burst(3, 1, 1);
        @(posedge clk_logic); #1;
        ch_out_size[1*LW +: LW] = 8'd0;
        wait_header(16'h0301, 20);
        ch_out_size[3*LW +: LW] = 8'd0;
        wait_out_empty("rr_reset_drain", 40);

        // Round robin over ch0, ch1, ch3 with a ch1 bubble
        ch_out_size[0*LW +: LW] = 8'd20;
        ch_out_size[1*LW +: LW] = 8'd20;
        ch_out_size[3*LW +: LW] = 8'd20;
        for (int r = 0; r < 2; r++) begin
            push_burst(0, 8, 8);
            push_burst(1, 8, 8);
            push_burst(3, 8, 8);
        end
        wait_header(16'h0108, 40);
        ch_out_valid[1] = 1'b0;
        @(negedge clk_logic);
        @(negedge clk_logic);
        check("bubble_stall", fifo_out_valid, 1'b0);
        @(posedge clk_logic); #1;
        ch_out_valid[1] = 1'b1;
        wait_header(16'h0308, 60);
        wait_header(16'h0308, 80);
        ch_out_size = '0;
        wait_out_empty("rr_drain", 60);
        repeat (4) @(negedge clk_logic);
        check("no_extra_burst", fifo_out_valid, 1'b0);

        // Inbound demux with ch1 backpressure
        @(posedge clk_logic); #1;
        in_q.push_back({8'd1, 16'h0AAA});
        in_q.push_back({8'd1, 16'h0BBB});
        in_q.push_back({8'd1, 16'h0CCC});
        in_q.push_back({8'd2, 16'h0DDD});
        send_in(16'h0103);
        send_in(16'h0AAA);
        ch_in_ready[1] = 1'b0;
        fifo_in_data = 16'h0BBB;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_logic);
            check("in_stall_ready", fifo_in_ready, 1'b0);
            check("in_stall_valid", ch_in_valid, 4'b0010);
            @(posedge clk_logic);
        end
        #1;
        ch_in_ready = '1;
        send_in(16'h0BBB);
        send_in(16'h0CCC);
        send_in(16'h0201);
        send_in(16'h0DDD);
        fifo_in_valid = 1'b0;
        check("in_demux_drain", in_q.size(), 0);

        // Drop to nonexistent channel, then deliver to ch0, then a zero-length header
        in_q.push_back({8'd0, 16'h3333});
        send_in(16'h0702);
        send_in(16'h1111);
        send_in(16'h2222);
        send_in(16'h0001);
        send_in(16'h3333);
        fifo_in_valid = 1'b0;
        check("drop_drain", in_q.size(), 0);
`ifdef GLIP_CHANNEL_MUX_STATS_EN
        check("stat_after_drop", stat_drop_words, 16'd2);
`else
        check("stat_after_drop", stat_drop_words, 16'd0);
`endif
        send_in(16'h0300);
        fifo_in_valid = 1'b0;
        @(negedge clk_logic);
`ifdef GLIP_CHANNEL_MUX_STATS_EN
        check("stat_after_len0", stat_drop_words, 16'd3);
`else
        check("stat_after_len0", stat_drop_words, 16'd0);
`endif
        check("len0_stays_hdr", fifo_in_ready, 1'b1);
        check("len0_no_valid", ch_in_valid, 4'b0000);

        check("final_out_q", out_q.size(), 0);
        check("final_in_q", in_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
